mem_port_arbiter: RTL and testbench
===================================

Name:
mem_port_arbiter

Overview:
Shares one single-ported unified memory between instruction fetch (IF) and the load/store unit (MEM stage) of the 5-stage core. Runs one transaction at a time. Data requests take fixed priority over fetch. Emits per-stage stall signals that the hazard unit ORs into its stall/flush network.

Parameters:
XLEN, 32, data/instruction width
ADDR_WIDTH, 32, byte address width

Ports:
clk  in  1  clock; single clock domain
rst  in  1  synchronous, active-high reset
if_req_i  in  1  fetch request; held until if_done_o
if_addr_i  in  ADDR_WIDTH  fetch PC
if_kill_i  in  1  redirect (PCSrcE); discard in-flight fetch
if_done_o  out  1  one-cycle fetch completion pulse
if_rdata_o  out  XLEN  fetched instruction; valid with if_done_o, held after
dm_req_i  in  1  data request; held until dm_done_o
dm_we_i  in  1  1 = store, 0 = load
dm_be_i  in  4  store byte enables
dm_addr_i  in  ADDR_WIDTH  data address
dm_wdata_i  in  XLEN  store data
dm_done_o  out  1  one-cycle data completion pulse
dm_rdata_o  out  XLEN  load data; valid with dm_done_o, held after
mem_req_o  out  1  memory command valid
mem_we_o  out  1  command write enable
mem_be_o  out  4  command byte enables
mem_addr_o  out  ADDR_WIDTH  command address
mem_wdata_o  out  XLEN  command write data
mem_ready_i  in  1  memory accepts command when mem_req_o && mem_ready_i
mem_rvalid_i  in  1  response strobe; one per command, writes included
mem_rdata_i  in  XLEN  response data
stall_f_o  out  1  comb: if_req_i && !if_done_o
stall_m_o  out  1  comb: dm_req_i && !dm_done_o

Behaviour:
- Reset: state IDLE; owner, kill flag, all registered outputs and rdata registers = 0.
- FSM states:
  - IDLE: arbitrate among requesters whose done_o is low this cycle. dm_req_i wins over if_req_i. On grant, latch cmd regs and owner, then go to REQ.
    - Fetch cmd: we = 0, be = 4'hF.
    - Data cmd: we, be, addr and wdata taken from dm_*.
  - REQ: mem_req_o = 1 with stable cmd until mem_ready_i. Then go to RESP.
  - RESP: wait for mem_rvalid_i. On rvalid: register mem_rdata_i into the owner's rdata register, pulse the owner's done_o next cycle, return to IDLE.
- mem_rvalid_i outside RESP is ignored. rvalid is never expected in the same cycle as acceptance.
- Data from mem_rdata_i is captured for writes as well; the value is don't-care.
- Zero-wait memory (ready = 1, rvalid the cycle after accept): request seen in IDLE at cycle 0, done at cycle 3.
- The done cycle excludes that requester from arbitration, so a held request is never re-issued.
- Back-to-back:
  - Data and fetch both pending: data first; fetch is granted in the IDLE cycle where dm_done_o = 1.
- Kill:
  - if_kill_i while owner = fetch in REQ or RESP sets the kill flag.
  - The command still completes; a command is never withdrawn once mem_req_o is asserted.
  - The response is consumed with no if_done_o and no rdata update. Kill flag clears on return to IDLE.
  - if_kill_i in IDLE, or while owner = data: no effect.
  - if_kill_i in the same cycle as if_done_o: pulse still issued; the pipeline's flush discards it.
- Request withdrawal: if_req_i dropping after grant without a kill is illegal for fetch. dm_req_i must not drop before dm_done_o (assertion).
- rdata registers hold their last value until overwritten.
- Reset mid-transaction: abandon immediately and return to IDLE. The memory is reset in the same cycle.

Decomposition:
- Shared package (core defines): arb_state_t enum {IDLE, REQ, RESP} and arb_owner_t enum {OWN_FETCH, OWN_DATA}.
- Fetch command constants in the same package: FETCH_BE = 4'hF, FETCH_WE = 1'b0.
- No sub-module: a single FSM plus command/response registers.

Test Plan:
- Lone fetch, addr 0x100, zero-wait memory, rdata 0x00000013 -> mem_req_o at cycle 1, if_done_o at cycle 3, if_rdata_o = 0x13, stall_f_o high cycles 0-2.
- Fetch 0x104 and load 0x2000 raised together, memory returns 0xDEADBEEF then 0x33 -> load issued first, dm_rdata_o = 0xDEADBEEF at cycle 3; fetch mem_req_o at cycle 4, if_done_o at cycle 6.
- Store addr 0x2004, be 4'b0011, wdata 0xA5A5 with mem_ready_i low 4 cycles -> mem_req_o and cmd stable for 5 cycles; dm_done_o 2 cycles after accept; no if_done_o.
- Fetch in RESP, if_kill_i pulsed, rvalid 2 cycles later -> no if_done_o, if_rdata_o unchanged; the next fetch (new PC) proceeds normally.
- rst asserted in REQ -> next cycle: IDLE, mem_req_o = 0, done outputs 0, rdata regs 0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and fetch command constants for the unified-memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } arb_state_t;

  typedef enum logic {
    OWN_FETCH,
    OWN_DATA
  } arb_owner_t;

  localparam logic [3:0] FETCH_BE = 4'hF;
  localparam logic       FETCH_WE = 1'b0;

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-transaction arbiter sharing one memory port between instruction fetch
// and the load/store unit; data has fixed priority over fetch.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  input  logic                  if_kill_i,
  output logic                  if_done_o,
  output logic [XLEN-1:0]       if_rdata_o,
  input  logic                  dm_req_i,
  input  logic                  dm_we_i,
  input  logic [3:0]            dm_be_i,
  input  logic [ADDR_WIDTH-1:0] dm_addr_i,
  input  logic [XLEN-1:0]       dm_wdata_i,
  output logic                  dm_done_o,
  output logic [XLEN-1:0]       dm_rdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [XLEN-1:0]       mem_wdata_o,
  input  logic                  mem_ready_i,
  input  logic                  mem_rvalid_i,
  input  logic [XLEN-1:0]       mem_rdata_i,
  output logic                  stall_f_o,
  output logic                  stall_m_o
);

  arb_state_t            state_q, state_d;
  arb_owner_t            owner_q, owner_d;
  logic                  kill_q, kill_d;
  logic                  we_q, we_d;
  logic [3:0]            be_q, be_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;
  logic                  if_done_q, if_done_d;
  logic                  dm_done_q, dm_done_d;
  logic [XLEN-1:0]       if_rdata_q, if_rdata_d;
  logic [XLEN-1:0]       dm_rdata_q, dm_rdata_d;
  logic                  kill_hit;

  assign kill_hit = if_kill_i && (owner_q == OWN_FETCH);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    kill_d     = kill_q;
    we_d       = we_q;
    be_d       = be_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    if_done_d  = 1'b0;
    dm_done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // A requester whose done pulse is showing now is still holding its
        // request; skipping it here prevents a duplicate issue.
        if (dm_req_i && !dm_done_q) begin
          owner_d = OWN_DATA;
          we_d    = dm_we_i;
          be_d    = dm_be_i;
          addr_d  = dm_addr_i;
          wdata_d = dm_wdata_i;
          kill_d  = 1'b0;
          state_d = REQ;
        end else if (if_req_i && !if_done_q) begin
          owner_d = OWN_FETCH;
          we_d    = FETCH_WE;
          be_d    = FETCH_BE;
          addr_d  = if_addr_i;
          wdata_d = '0;
          kill_d  = 1'b0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (kill_hit) kill_d = 1'b1;
        if (mem_ready_i) state_d = RESP;
      end
      RESP: begin
        if (kill_hit) kill_d = 1'b1;
        if (mem_rvalid_i) begin
          state_d = IDLE;
          kill_d  = 1'b0;
          if (owner_q == OWN_DATA) begin
            dm_rdata_d = mem_rdata_i;
            dm_done_d  = 1'b1;
          end else if (!(kill_q || if_kill_i)) begin
            if_rdata_d = mem_rdata_i;
            if_done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_FETCH;
      kill_q     <= 1'b0;
      we_q       <= 1'b0;
      be_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_done_q  <= 1'b0;
      dm_done_q  <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      kill_q     <= kill_d;
      we_q       <= we_d;
      be_q       <= be_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_done_q  <= if_done_d;
      dm_done_q  <= dm_done_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign mem_req_o   = (state_q == REQ);
  assign mem_we_o    = we_q;
  assign mem_be_o    = be_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign if_done_o   = if_done_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_done_o   = dm_done_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign stall_f_o   = if_req_i && !if_done_q;
  assign stall_m_o   = dm_req_i && !dm_done_q;

  // The load/store unit may not abandon a granted data access.
  dm_req_held: assert property (@(posedge clk) disable iff (rst)
    ((state_q != IDLE) && (owner_q == OWN_DATA)) |-> dm_req_i);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed cycle-exact scenarios
// followed by randomized traffic against a word-addressed memory model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i, if_kill_i, if_done_o;
  logic [31:0] if_addr_i, if_rdata_o;
  logic        dm_req_i, dm_we_i, dm_done_o;
  logic [3:0]  dm_be_i;
  logic [31:0] dm_addr_i, dm_wdata_i, dm_rdata_o;
  logic        mem_req_o, mem_we_o, mem_ready_i, mem_rvalid_i;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        stall_f_o, stall_m_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        is_data;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } cmd_t;

  logic [31:0] ref_mem  [int];
  logic [31:0] phys_mem [int];

  mem_port_arbiter #(.XLEN(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_kill_i(if_kill_i),
    .if_done_o(if_done_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_be_i(dm_be_i),
    .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_done_o(dm_done_o), .dm_rdata_o(dm_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ready_i(mem_ready_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .stall_f_o(stall_f_o), .stall_m_o(stall_m_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req_i = 0; if_addr_i = 0; if_kill_i = 0;
    dm_req_i = 0; dm_we_i = 0; dm_be_i = 0; dm_addr_i = 0; dm_wdata_i = 0;
    mem_ready_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
  endtask

  function automatic logic [31:0] init_word(logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h13572468;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(logic [31:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_word(a);
  endfunction

  function automatic logic [31:0] phys_rd(logic [31:0] a);
    return phys_mem.exists(int'(a)) ? phys_mem[int'(a)] : init_word(a);
  endfunction

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    repeat (3) tick();
    #1;
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL reset mem_req got %b exp 0", mem_req_o); end
    checks++; if (if_done_o !== 1'b0 || dm_done_o !== 1'b0) begin errors++; $display("FAIL reset done got %b%b exp 00", if_done_o, dm_done_o); end
    checks++; if (if_rdata_o !== 32'h0 || dm_rdata_o !== 32'h0) begin errors++; $display("FAIL reset rdata got %h %h exp 0 0", if_rdata_o, dm_rdata_o); end
    checks++; if (stall_f_o !== 1'b0 || stall_m_o !== 1'b0) begin errors++; $display("FAIL reset stall got %b%b exp 00", stall_f_o, stall_m_o); end
    rst = 0;
    $display("reset: done");
  endtask

  task automatic test_lone_fetch();
    for (int c = 0; c < 6; c++) begin
      tick();
      if_req_i = (c <= 3); if_addr_i = 32'h100; mem_ready_i = 1;
      mem_rvalid_i = (c == 2); mem_rdata_i = (c == 2) ? 32'h13 : 32'hFFFF_FFFF;
      #1;
      checks++; if (mem_req_o !== (c == 1)) begin errors++; $display("FAIL lone_fetch mem_req c=%0d got %b exp %b", c, mem_req_o, c == 1); end
      checks++; if (if_done_o !== (c == 3)) begin errors++; $display("FAIL lone_fetch if_done c=%0d got %b exp %b", c, if_done_o, c == 3); end
      checks++; if (stall_f_o !== (c <= 2)) begin errors++; $display("FAIL lone_fetch stall_f c=%0d got %b exp %b", c, stall_f_o, c <= 2); end
      checks++; if (dm_done_o !== 1'b0) begin errors++; $display("FAIL lone_fetch dm_done c=%0d got %b exp 0", c, dm_done_o); end
      if (c == 1) begin
        checks++; if (mem_addr_o !== 32'h100 || mem_we_o !== 1'b0 || mem_be_o !== 4'hF) begin
          errors++; $display("FAIL lone_fetch cmd got a=%h we=%b be=%h exp a=100 we=0 be=f", mem_addr_o, mem_we_o, mem_be_o); end
      end
      if (c >= 3) begin
        checks++; if (if_rdata_o !== 32'h13) begin errors++; $display("FAIL lone_fetch if_rdata c=%0d got %h exp 00000013", c, if_rdata_o); end
      end
    end
    $display("lone_fetch: addr 100 rdata %h", if_rdata_o);
  endtask

  task automatic test_data_priority();
    for (int c = 0; c < 9; c++) begin
      tick();
      if_req_i = (c <= 6); if_addr_i = 32'h104;
      dm_req_i = (c <= 3); dm_we_i = 0; dm_be_i = 4'h0; dm_addr_i = 32'h2000; dm_wdata_i = 0;
      mem_ready_i = 1; mem_rvalid_i = (c == 2 || c == 5);
      mem_rdata_i = (c == 2) ? 32'hDEADBEEF : (c == 5) ? 32'h33 : 32'h0;
      #1;
      checks++; if (mem_req_o !== (c == 1 || c == 4)) begin errors++; $display("FAIL priority mem_req c=%0d got %b", c, mem_req_o); end
      checks++; if (dm_done_o !== (c == 3)) begin errors++; $display("FAIL priority dm_done c=%0d got %b exp %b", c, dm_done_o, c == 3); end
      checks++; if (if_done_o !== (c == 6)) begin errors++; $display("FAIL priority if_done c=%0d got %b exp %b", c, if_done_o, c == 6); end
      checks++; if (stall_m_o !== (c <= 2)) begin errors++; $display("FAIL priority stall_m c=%0d got %b exp %b", c, stall_m_o, c <= 2); end
      checks++; if (stall_f_o !== (c <= 5)) begin errors++; $display("FAIL priority stall_f c=%0d got %b exp %b", c, stall_f_o, c <= 5); end
      if (c == 1) begin
        checks++; if (mem_addr_o !== 32'h2000 || mem_we_o !== 1'b0) begin errors++; $display("FAIL priority first_cmd got a=%h we=%b exp a=2000 we=0", mem_addr_o, mem_we_o); end
      end
      if (c == 4) begin
        checks++; if (mem_addr_o !== 32'h104 || mem_be_o !== 4'hF) begin errors++; $display("FAIL priority second_cmd got a=%h be=%h exp a=104 be=f", mem_addr_o, mem_be_o); end
      end
      if (c >= 3) begin
        checks++; if (dm_rdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL priority dm_rdata c=%0d got %h exp deadbeef", c, dm_rdata_o); end
      end
      if (c >= 6) begin
        checks++; if (if_rdata_o !== 32'h33) begin errors++; $display("FAIL priority if_rdata c=%0d got %h exp 00000033", c, if_rdata_o); end
      end
    end
    $display("data_priority: dm %h if %h", dm_rdata_o, if_rdata_o);
  endtask

  task automatic test_store_wait();
    idle_inputs();
    for (int c = 0; c < 10; c++) begin
      tick();
      dm_req_i = (c <= 7); dm_we_i = 1; dm_be_i = 4'b0011; dm_addr_i = 32'h2004; dm_wdata_i = 32'hA5A5;
      mem_ready_i = (c == 5); mem_rvalid_i = (c == 6); mem_rdata_i = 32'h1234_5678;
      #1;
      checks++; if (mem_req_o !== (c >= 1 && c <= 5)) begin errors++; $display("FAIL store mem_req c=%0d got %b", c, mem_req_o); end
      if (c >= 1 && c <= 5) begin
        checks++; if (mem_addr_o !== 32'h2004 || mem_we_o !== 1'b1 || mem_be_o !== 4'b0011 || mem_wdata_o !== 32'hA5A5) begin
          errors++; $display("FAIL store cmd c=%0d got a=%h we=%b be=%h wd=%h", c, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o); end
      end
      checks++; if (dm_done_o !== (c == 7)) begin errors++; $display("FAIL store dm_done c=%0d got %b exp %b", c, dm_done_o, c == 7); end
      checks++; if (if_done_o !== 1'b0) begin errors++; $display("FAIL store if_done c=%0d got %b exp 0", c, if_done_o); end
      checks++; if (stall_m_o !== (c <= 6)) begin errors++; $display("FAIL store stall_m c=%0d got %b exp %b", c, stall_m_o, c <= 6); end
    end
    $display("store_wait: addr 2004 be 3 wdata a5a5");
  endtask

  task automatic test_kill();
    idle_inputs();
    for (int c = 0; c < 11; c++) begin
      tick();
      if_req_i = (c <= 8); if_addr_i = (c <= 2) ? 32'h200 : 32'h300;
      if_kill_i = (c == 2); mem_ready_i = 1; mem_rvalid_i = (c == 4 || c == 7);
      mem_rdata_i = (c == 4) ? 32'hBAD0BAD0 : (c == 7) ? 32'h77 : 32'h0;
      #1;
      checks++; if (mem_req_o !== (c == 1 || c == 6)) begin errors++; $display("FAIL kill mem_req c=%0d got %b", c, mem_req_o); end
      checks++; if (if_done_o !== (c == 8)) begin errors++; $display("FAIL kill if_done c=%0d got %b exp %b", c, if_done_o, c == 8); end
      checks++; if (if_rdata_o !== ((c >= 8) ? 32'h77 : 32'h33)) begin errors++; $display("FAIL kill if_rdata c=%0d got %h", c, if_rdata_o); end
      if (c == 6) begin
        checks++; if (mem_addr_o !== 32'h300) begin errors++; $display("FAIL kill new_pc got %h exp 00000300", mem_addr_o); end
      end
    end
    $display("kill: refetch rdata %h", if_rdata_o);
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    for (int c = 0; c < 4; c++) begin
      tick();
      dm_req_i = (c <= 1); dm_addr_i = 32'h2008; rst = (c == 1);
      #1;
      if (c == 1) begin
        checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL reset_mid pre mem_req got %b exp 1", mem_req_o); end
      end
      if (c >= 2) begin
        checks++; if (mem_req_o !== 1'b0 || if_done_o !== 1'b0 || dm_done_o !== 1'b0) begin
          errors++; $display("FAIL reset_mid outputs c=%0d got req=%b if=%b dm=%b exp 000", c, mem_req_o, if_done_o, dm_done_o); end
        checks++; if (if_rdata_o !== 32'h0 || dm_rdata_o !== 32'h0) begin
          errors++; $display("FAIL reset_mid rdata c=%0d got %h %h exp 0 0", c, if_rdata_o, dm_rdata_o); end
      end
    end
    rst = 0;
    $display("reset_mid: abandoned load");
  endtask

  task automatic test_random();
    cmd_t        exp_q[$];
    cmd_t        cm;
    logic        has_f, has_d, d_we, f_seen, d_seen, pend;
    logic [3:0]  d_be;
    logic [31:0] f_addr, d_addr, d_wdata, exp_d, exp_f, resp_data;
    int          cnt, extra, cyc;
    idle_inputs();
    pend = 0; cnt = 0; resp_data = 0;
    for (int g = 0; g < 30; g++) begin
      has_f = 1'($urandom_range(0, 1)); has_d = 1'($urandom_range(0, 1));
      if (!has_f && !has_d) has_f = 1;
      d_we = 1'($urandom_range(0, 1)); d_be = 4'($urandom_range(1, 15));
      d_addr = 32'h3000 + 4 * $urandom_range(0, 7);
      f_addr = 32'h3000 + 4 * $urandom_range(0, 7);
      d_wdata = $urandom;
      exp_d = 0;
      if (has_d) begin
        exp_d = ref_rd(d_addr);
        cm = '{1'b1, d_addr, d_we, d_be, d_wdata};
        exp_q.push_back(cm);
        if (d_we) ref_mem[int'(d_addr)] = merge(ref_rd(d_addr), d_wdata, d_be);
      end
      exp_f = ref_rd(f_addr);
      if (has_f) begin
        cm = '{1'b0, f_addr, 1'b0, 4'hF, 32'h0};
        exp_q.push_back(cm);
      end
      f_seen = !has_f; d_seen = !has_d; extra = 0; cyc = 0;
      while (extra < 2 && cyc < 80) begin
        tick();
        cyc++;
        if_req_i = !f_seen; if_addr_i = f_addr;
        dm_req_i = !d_seen; dm_we_i = d_we; dm_be_i = d_be; dm_addr_i = d_addr; dm_wdata_i = d_wdata;
        mem_ready_i = 1'($urandom_range(0, 1));
        mem_rvalid_i = 0; mem_rdata_i = $urandom;
        if (pend) begin
          if (cnt == 0) begin mem_rvalid_i = 1; mem_rdata_i = resp_data; pend = 0; end
          else cnt--;
        end
        if (mem_req_o && mem_ready_i) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++; $display("FAIL random unexpected_cmd g=%0d got a=%h exp none", g, mem_addr_o);
          end else begin
            cm = exp_q.pop_front();
            if (mem_addr_o !== cm.addr || mem_we_o !== cm.we || mem_be_o !== cm.be ||
                (cm.is_data && mem_wdata_o !== cm.wdata)) begin
              errors++; $display("FAIL random cmd g=%0d got a=%h we=%b be=%h wd=%h exp a=%h we=%b be=%h wd=%h",
                                 g, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o, cm.addr, cm.we, cm.be, cm.wdata);
            end
          end
          if (mem_we_o) phys_mem[int'(mem_addr_o)] = merge(phys_rd(mem_addr_o), mem_wdata_o, mem_be_o);
          resp_data = mem_we_o ? $urandom : phys_rd(mem_addr_o);
          pend = 1; cnt = $urandom_range(0, 2);
        end
        #1;
        if (dm_done_o) begin
          checks++;
          if (d_seen) begin errors++; $display("FAIL random spurious_dm_done g=%0d got 1 exp 0", g); end
          else if (!d_we && dm_rdata_o !== exp_d) begin errors++; $display("FAIL random dm_rdata g=%0d got %h exp %h", g, dm_rdata_o, exp_d); end
          d_seen = 1;
        end
        if (if_done_o) begin
          checks++;
          if (f_seen || !d_seen) begin errors++; $display("FAIL random if_done_order g=%0d got f_seen=%b d_seen=%b exp 0 1", g, f_seen, d_seen); end
          else if (if_rdata_o !== exp_f) begin errors++; $display("FAIL random if_rdata g=%0d got %h exp %h", g, if_rdata_o, exp_f); end
          f_seen = 1;
        end
        if (f_seen && d_seen && !pend) extra++;
      end
      checks++;
      if (!(f_seen && d_seen) || exp_q.size() != 0) begin
        errors++; $display("FAIL random timeout g=%0d got f=%b d=%b left=%0d exp 1 1 0", g, f_seen, d_seen, exp_q.size());
        exp_q.delete();
      end
      $display("random g=%0d f=%b d=%b we=%b daddr=%h faddr=%h cycles=%0d", g, has_f, has_d, d_we, d_addr, f_addr, cyc);
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    test_reset();
    test_lone_fetch();
    test_data_priority();
    test_store_wait();
    test_kill();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
